jk_excitation_counter: RTL and testbench

- Synchronous up/down modulo-N counter. The state is held in WIDTH JK storage cells.
- Per-bit J/K inputs are produced by excitation logic. This logic is the inverse of the JK characteristic: it takes the present Q and the desired next Q and derives J/K.
- Used as the standard counter and sequencer primitive in the flip-flop lab chain. It also exposes J/K so benches can check the excitation table directly.

---
 rtl/lab_ff_pkg.sv | 23 ++
 rtl/jk_cell.sv | 26 ++
 rtl/jk_excitation_counter.sv | 97 +++++++++
 tb/tb_jk_excitation_counter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lab_ff_pkg.sv
// Shared definitions for the flip-flop lab chain: JK input encodings and
// the excitation function that recovers J/K from a present/next bit pair.
package lab_ff_pkg;

  // {J,K} encodings as driven into a JK cell
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // Inverse of the JK characteristic. Don't-cares are resolved to 0, so
  // a bit that keeps its value always gets HOLD and toggle is never produced.
  function automatic logic [1:0] jk_excite(input logic q_bit, input logic nxt_bit);
    logic [1:0] jk;
    case ({q_bit, nxt_bit})
      2'b01:   jk = JK_SET;
      2'b10:   jk = JK_CLR;
      default: jk = JK_HOLD;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK storage bit, updated on the falling clock edge.
module jk_cell
  import lab_ff_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK characteristic: hold / clear / set / toggle; reset wins over J/K
  always_ff @(negedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_excitation_counter.sv
// Up/down modulo-N counter whose state lives in JK cells. The next count is
// computed as a target value, then turned into per-bit J/K via excitation
// logic; the cells are the only path by which the count changes.
module jk_excitation_counter
  import lab_ff_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             tc,
  output logic             load_err
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("jk_excitation_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  // Highest count value, and the modulus widened by one bit so that
  // MODULUS == 2**WIDTH still compares correctly against din.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] nxt;
  logic             load_bad;

  // Target next state: load beats count beats hold; an out-of-range load
  // parks the counter at zero and flags the error.
  always_comb begin
    nxt      = q;
    load_bad = 1'b0;
    if (load) begin
      if ({1'b0, din} < MOD_EXT) begin
        nxt = din;
      end else begin
        nxt      = '0;
        load_bad = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        nxt = (q == MAX_VAL) ? '0 : q + WIDTH'(1);
      end else begin
        nxt = (q == '0) ? MAX_VAL : q - WIDTH'(1);
      end
    end
  end

  // Per-bit excitation: derive J/K that move each cell from q to nxt
  always_comb begin
    j_out = '0;
    k_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j_out[i], k_out[i]} = jk_excite(q[i], nxt[i]);
    end
  end

  // Storage: one JK cell per count bit
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cells
      jk_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .j     (j_out[gi]),
        .k     (k_out[gi]),
        .q     (q[gi])
      );
    end
  endgenerate

  // Terminal count: about to wrap in the current direction, suppressed by
  // load and by reset
  always_comb begin
    tc = ~reset & en & ~load &
         ((up_dn & (q == MAX_VAL)) | (~up_dn & (q == '0)));
  end

  // Illegal-load flag: one cycle after the offending load, cleared otherwise
  always_ff @(negedge clk) begin
    if (reset) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load_bad;
    end
  end

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Self-checking bench for jk_excitation_counter: a directed vector table,
// then a random run against a behavioural model, with a scoreboard queue
// carrying the post-edge expectations.
module tb_jk_excitation_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk;
  logic             reset;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             tc;
  logic             load_err;

  jk_excitation_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .din      (din),
    .q        (q),
    .j_out    (j_out),
    .k_out    (k_out),
    .tc       (tc),
    .load_err (load_err)
  );

  // free-running clock, falling edges at 5, 15, 25, ...
  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, e, u, l;
    logic [3:0] d;
    logic [3:0] eq, ej, ek;
    logic       etc, eerr;
    bit         cj;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  // behavioural model state
  int   mq   = 0;
  logic merr = 1'b0;

  function automatic vec_t mk(logic r, e, u, l, logic [3:0] d, logic [3:0] eq, ej, ek,
                              logic etc, eerr, bit cj);
    vec_t v;
    v.r = r; v.e = e; v.u = u; v.l = l; v.d = d;
    v.eq = eq; v.ej = ej; v.ek = ek; v.etc = etc; v.eerr = eerr; v.cj = cj;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // model: expected combinational outputs now and state after the edge
  task automatic modelExpect(input logic r, e, u, l, input logic [3:0] d,
                             output logic [3:0] eq, ej, ek, output logic etc, eerr);
    int nx;
    logic [3:0] cur, nv;
    nx   = mq;
    eerr = 1'b0;
    if (l) begin
      if (int'(d) < MODULUS) nx = int'(d);
      else begin nx = 0; eerr = 1'b1; end
    end else if (e) begin
      nx = u ? (mq + 1) % MODULUS : (mq + MODULUS - 1) % MODULUS;
    end
    cur = 4'(mq);
    nv  = 4'(nx);
    ej  = ~cur & nv;
    ek  = cur & ~nv;
    etc = !r && e && !l && ((u && mq == MODULUS - 1) || (!u && mq == 0));
    if (r) begin nx = 0; eerr = 1'b0; end
    eq = 4'(nx);
  endtask

  // drive one cycle of inputs, check combinational outputs, queue expectations
  task automatic applyStimulus(input vec_t v, input string tag);
    logic [3:0] mq_n, mj, mk_, dummy;
    logic       mt, me;
    reset = v.r; en = v.e; up_dn = v.u; load = v.l; din = v.d;
    sb.push_back('{q: v.eq, err: v.eerr});
    #2;
    check({tag, " tc"}, 32'(tc), 32'(v.etc));
    if (v.cj) begin
      check({tag, " j_out"}, 32'(j_out), 32'(v.ej));
      check({tag, " k_out"}, 32'(k_out), 32'(v.ek));
      check({tag, " no_toggle"}, 32'(j_out & k_out), 32'd0);
    end
    modelExpect(v.r, v.e, v.u, v.l, v.d, mq_n, mj, mk_, mt, me);
    dummy = mj ^ mk_;
    mq   = int'(mq_n);
    merr = me;
  endtask

  // wait for the falling edge and compare the state the DUT produced
  task automatic checkOutput(input string tag);
    exp_t x;
    @(negedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      x = sb.pop_front();
      check({tag, " q"}, 32'(q), 32'(x.q));
      check({tag, " load_err"}, 32'(load_err), 32'(x.err));
    end
  endtask

  initial begin
    vec_t v;
    logic [3:0] eq, ej, ek;
    logic       etc, eerr;

    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; din = '0;
    @(negedge clk);
    #1;

    //          r  e  u  l  din     q      j        k       tc eerr cj
    // reset held with en and load active
    vecs.push_back(mk(1, 1, 1, 1, 4'd7, 4'd0, 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 4'd7, 4'd0, 4'b0000, 4'b0000, 0, 0, 0));
    // up count 0..9, wrap, 1, 2
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd1, 4'b0001, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd2, 4'b0010, 4'b0001, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd3, 4'b0001, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd4, 4'b0100, 4'b0011, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd5, 4'b0001, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd6, 4'b0010, 4'b0001, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd7, 4'b0001, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd8, 4'b1000, 4'b0111, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd9, 4'b0001, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd0, 4'b0000, 4'b1001, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd1, 4'b0001, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd2, 4'b0010, 4'b0001, 0, 0, 1));
    // load 0, then down count with wrap to 9
    vecs.push_back(mk(0, 1, 0, 1, 4'd0, 4'd0, 4'b0000, 4'b0010, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 4'd0, 4'd9, 4'b1001, 4'b0000, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 4'd0, 4'd8, 4'b0000, 4'b0001, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 4'd0, 4'd7, 4'b0111, 4'b1000, 0, 0, 1));
    // load beats count, then illegal load and its one-cycle flag
    vecs.push_back(mk(0, 1, 0, 1, 4'd5, 4'd5, 4'b0000, 4'b0010, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 4'd12, 4'd0, 4'b0000, 4'b0101, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'd0, 4'd0, 4'b0000, 4'b0000, 0, 0, 1));
    // load 6, hold three edges
    vecs.push_back(mk(0, 0, 1, 1, 4'd6, 4'd6, 4'b0110, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'd0, 4'd6, 4'b0000, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd6, 4'b0000, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'd0, 4'd6, 4'b0000, 4'b0000, 0, 0, 1));
    // direction flip every edge
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd7, 4'b0001, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 4'd0, 4'd6, 4'b0000, 4'b0001, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd7, 4'b0001, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 4'd0, 4'd6, 4'b0000, 4'b0001, 0, 0, 1));
    // count to 8, reset mid-count, resume from 0
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd7, 4'b0001, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd8, 4'b1000, 4'b0111, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 4'd0, 4'd0, 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd1, 4'b0001, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd2, 4'b0010, 4'b0001, 0, 0, 1));

    mq = 0; merr = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d", i));
    end

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      v.r = ($urandom_range(0, 49) == 0);
      v.e = $urandom_range(0, 3) != 0;
      v.u = $urandom_range(0, 1) != 0;
      v.l = ($urandom_range(0, 5) == 0);
      v.d = 4'($urandom_range(0, 15));
      modelExpect(v.r, v.e, v.u, v.l, v.d, eq, ej, ek, etc, eerr);
      v.eq = eq; v.ej = ej; v.ek = ek; v.etc = etc; v.eerr = eerr;
      v.cj = !v.r;
      applyStimulus(v, $sformatf("rnd%0d", n));
      checkOutput($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
